// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3 from digits >= 8).
// Optional input digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Smallest binary width able to hold 10^d - 1.
  function automatic int unsigned min_bin_w(input int unsigned d);
    longint unsigned p;
    int unsigned     b;
    p = 64'd1;
    b = 0;
    for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
    for (int unsigned i = 0; i < 64; i++)
      if ((64'd1 << i) < p) b = i + 1;
    return b;
  endfunction

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  // Subtract 3 from every BCD field that reads 8 or more after the shift.
  function automatic logic [SR_W-1:0] correct(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    r = v;
    for (int unsigned d = 0; d < DIGITS; d++)
      if (r[BIN_W + 4*d +: 4] >= 4'd8)
        r[BIN_W + 4*d +: 4] = r[BIN_W + 4*d +: 4] - 4'd3;
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [SR_W-1:0]   r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [BIN_W-1:0]  r_bin;
  logic [SR_W-1:0]   w_sr_next;

  assign w_sr_next = correct(r_sr >> 1);

`ifdef BCD2BIN_CHECK_EN
  logic r_err;
  logic w_digit_bad;

  always_comb begin
    w_digit_bad = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++)
      if (bcd_in[4*d +: 4] > 4'd9) w_digit_bad = 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bin       <= '0;
`ifdef BCD2BIN_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            r_err <= w_digit_bad;
            if (w_digit_bad) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_bin       <= '0;
            end else
`endif
            begin
              r_sr    <= {bcd_in, BIN_W'(0)};
              r_cnt   <= CNT_W'(BIN_W);
              r_busy  <= 1'b1;
              r_state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_bin       <= w_sr_next[BIN_W-1:0];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bin_out   = r_bin;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10); covers BCD2BIN_CHECK_EN when defined.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  bcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIN_W-1:0]     bin_out;
  logic                 err;
  logic                 busy;

  int vectors     = 0;
  int miscompares = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: decimal value to packed BCD.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v, output int ok);
    int n;
    n = 0;
    bcd_in   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    ok = int'(in_ready);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (bin_out !== '0) begin miscompares++; $display("FAIL reset_bin_out: got %0d want 0", bin_out); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_known();
    logic [11:0] vin [4] = '{12'h000, 12'h999, 12'h255, 12'h128};
    int          vexp[4] = '{0, 999, 255, 128};
    int ok, n;
    for (int i = 0; i < 4; i++) begin
      send(vin[i], ok);
      vectors++; if (ok != 1) begin miscompares++; $display("FAIL known_accept[%0d]: in_ready never high", i); end
      wait_out(n);
      vectors++; if (n != int'(BIN_W)) begin miscompares++; $display("FAIL known_latency[%0d]: got %0d want %0d", i, n, BIN_W); end
      vectors++; if (int'(bin_out) != vexp[i]) begin miscompares++; $display("FAIL known_value[%0d]: got %0d want %0d", i, bin_out, vexp[i]); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL known_err[%0d]: got %b want 0", i, err); end
      consume();
    end
  endtask

  task automatic test_stall();
    int ok, n;
    send(to_bcd(537), ok);
    wait_out(n);
    vectors++; if (int'(bin_out) != 537) begin miscompares++; $display("FAIL stall_first: got %0d want 537", bin_out); end
    bcd_in = to_bcd(264); in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++; if (int'(bin_out) != 537) begin miscompares++; $display("FAIL stall_hold[%0d]: got %0d want 537", c, bin_out); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid[%0d]: got %b want 1", c, out_valid); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_second_busy: got %b want 1", busy); end
    wait_out(n);
    vectors++; if (n != int'(BIN_W)) begin miscompares++; $display("FAIL stall_second_latency: got %0d want %0d", n, BIN_W); end
    vectors++; if (int'(bin_out) != 264) begin miscompares++; $display("FAIL stall_second_value: got %0d want 264", bin_out); end
    consume();
  endtask

  task automatic test_reset_mid();
    int ok, n;
    send(to_bcd(777), ok);
    repeat (3) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    send(12'h042, ok);
    wait_out(n);
    vectors++; if (n != int'(BIN_W)) begin miscompares++; $display("FAIL midrst_latency: got %0d want %0d", n, BIN_W); end
    vectors++; if (int'(bin_out) != 42) begin miscompares++; $display("FAIL midrst_value: got %0d want 42", bin_out); end
    consume();
  endtask

`ifdef BCD2BIN_CHECK_EN
  task automatic test_check();
    int ok, n;
    send(12'h1A5, ok);
    wait_out(n);
    vectors++; if (n != 1) begin miscompares++; $display("FAIL check_latency: got %0d want 1", n); end
    vectors++; if (bin_out !== '0) begin miscompares++; $display("FAIL check_bin: got %0d want 0", bin_out); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL check_err: got %b want 1", err); end
    consume();
    send(12'h305, ok);
    wait_out(n);
    vectors++; if (n != int'(BIN_W)) begin miscompares++; $display("FAIL check_legal_latency: got %0d want %0d", n, BIN_W); end
    vectors++; if (int'(bin_out) != 305) begin miscompares++; $display("FAIL check_legal_value: got %0d want 305", bin_out); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL check_legal_err: got %b want 0", err); end
    consume();
  endtask
`endif

  task automatic test_back_to_back();
    int ok, n, m, first;
    logic prev, accepted, got_first;
    out_ready = 1'b1;
    send(12'h001, ok);
    bcd_in = 12'h998; in_valid = 1'b1;
    n = 0; accepted = 1'b0; got_first = 1'b0; first = -1;
    while (!accepted && n < 100) begin
      prev = in_ready;
      tick();
      n++;
      if (out_valid) begin first = int'(bin_out); got_first = 1'b1; end
      if (prev) accepted = 1'b1;
    end
    in_valid = 1'b0;
    vectors++; if (got_first !== 1'b1 || first != 1) begin miscompares++; $display("FAIL b2b_first: got %0d want 1", first); end
    vectors++; if (n != int'(BIN_W) + 2) begin miscompares++; $display("FAIL b2b_period: got %0d want %0d", n, BIN_W + 2); end
    wait_out(m);
    vectors++; if (m != int'(BIN_W)) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", m, BIN_W); end
    vectors++; if (int'(bin_out) != 998) begin miscompares++; $display("FAIL b2b_second: got %0d want 998", bin_out); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int ok, n, v, stall;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 999));
      send(to_bcd(v), ok);
      wait_out(n);
      vectors++; if (n != int'(BIN_W)) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, n, BIN_W); end
      vectors++; if (int'(bin_out) != v) begin miscompares++; $display("FAIL rand_value[%0d]: got %0d want %0d", i, bin_out, v); end
      stall = int'($urandom_range(0, 3));
      repeat (stall) tick();
      vectors++; if (out_valid !== 1'b1 || int'(bin_out) != v) begin miscompares++; $display("FAIL rand_hold[%0d]: valid %b value %0d want 1/%0d", i, out_valid, bin_out, v); end
      consume();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    test_reset();
    test_known();
    test_stall();
    test_reset_mid();
`ifdef BCD2BIN_CHECK_EN
    test_check();
`endif
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
